knock_detect: RTL

Front-end conditioner that turns the raw piezo/knock-sensor line into the clean, active-low `KNOCK` strobe consumed by the knock-timer/LED block. It synchronises the asynchronous sensor input, debounces it, and emits exactly one fixed-width low pulse per accepted knock. It then enforces a refractory lockout so that sensor ringing cannot register as extra minutes. It sits between the board pin and the timer on the 1 kHz clock domain.

---
 rtl/knock_pkg.sv | 24 ++
 rtl/knock_sync.sv | 24 ++
 rtl/knock_detect.sv | 121 ++++++++++++
 3 files changed

// File: rtl/knock_pkg.sv
// Shared types and default timing for the knock-sensor front end.
// Timing constants are in 1 kHz clock cycles (milliseconds).
package knock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    PULSE,
    LOCKOUT,
    RELEASE
  } knock_st_t;

  localparam int         DEBOUNCE_MS_DEF = 20;
  localparam int         HOLD_MS_DEF     = 50;
  localparam int         REFRACT_MS_DEF  = 200;
  localparam logic [7:0] KNOCK_CNT_MAX   = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/knock_sync.sv
// Two-flop synchroniser that brings the raw sensor line into the CLK1K domain.
module knock_sync (
  input  logic CLK1K,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/knock_detect.sv
// Knock-sensor conditioner: synchronise, debounce, emit one fixed-width
// active-low KNOCK strobe per accepted knock, then lock out sensor ringing.
module knock_detect
  import knock_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int HOLD_MS     = HOLD_MS_DEF,
  parameter int REFRACT_MS  = REFRACT_MS_DEF
) (
  input  logic       CLK1K,
  input  logic       RST,
  input  logic       KNOCK_RAW,
  input  logic       EN,
  output logic       KNOCK,
  output logic       BUSY,
  output logic [7:0] KNOCK_CNT
);

  localparam int TW = $clog2(max3(DEBOUNCE_MS, HOLD_MS, REFRACT_MS)) + 1;
  localparam logic [TW-1:0] T_DEB  = TW'(DEBOUNCE_MS - 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLD_MS - 1);
  localparam logic [TW-1:0] T_REF  = TW'(REFRACT_MS - 1);

  logic w_s2;

  knock_sync u_sync (
    .CLK1K (CLK1K),
    .RST   (RST),
    .i_d   (KNOCK_RAW),
    .o_q   (w_s2)
  );

  knock_st_t     r_state;
  knock_st_t     w_state_next;
  logic [TW-1:0] r_t;
  logic [TW-1:0] w_t_next;
  logic          r_knock;
  logic          w_knock_next;
  logic          r_busy;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_next;

  always_ff @(posedge CLK1K) begin
    if (RST) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_knock <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_t     <= w_t_next;
      r_knock <= w_knock_next;
      r_busy  <= (w_state_next != IDLE);
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    w_knock_next = r_knock;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_knock_next = 1'b1;
        if (EN && w_s2) begin
          w_state_next = DEBOUNCE;
          w_t_next     = '0;
        end
      end
      DEBOUNCE: begin
        // Abort has priority, so EN dropping on the final debounce cycle wins.
        if (!w_s2 || !EN) begin
          w_state_next = IDLE;
        end else if (r_t == T_DEB) begin
          w_state_next = PULSE;
          w_t_next     = '0;
          w_knock_next = 1'b0;
          w_cnt_next   = (r_cnt == KNOCK_CNT_MAX) ? r_cnt : r_cnt + 8'd1;
        end else begin
          w_t_next = r_t + 1'b1;
        end
      end
      PULSE: begin
        w_knock_next = 1'b0;
        if (r_t == T_HOLD) begin
          w_state_next = LOCKOUT;
          w_t_next     = '0;
          w_knock_next = 1'b1;
        end else begin
          w_t_next = r_t + 1'b1;
        end
      end
      LOCKOUT: begin
        if (r_t == T_REF) begin
          w_state_next = RELEASE;
          w_t_next     = '0;
        end else begin
          w_t_next = r_t + 1'b1;
        end
      end
      RELEASE: begin
        // Sensor must return low before a new knock can be considered.
        if (!w_s2) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_t_next     = '0;
        w_knock_next = 1'b1;
      end
    endcase
  end

  assign KNOCK     = r_knock;
  assign BUSY      = r_busy;
  assign KNOCK_CNT = r_cnt;

endmodule
